// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage of the pipelined LEGv8 CPU. Owns the
//             program counter, drives the instruction-memory address and
//             registers the fetched instruction plus its PC into the IF/ID
//             boundary. Honours a load-use stall and a taken-branch redirect
//             (redirect wins), and keeps fetch / bubble counters for CPI.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             stall             - hold PC and IF/ID
//             br_taken/br_target- redirect fetch, squash IF/ID with a NOP
//             imem_addr/instr   - combinational instruction-memory port
//             pc_out            - current PC
//             instr_out, pcaddr_out, valid_out - IF/ID contents
//             fetch_cnt, bubble_cnt            - free-running counters
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] pc_out,
  output logic [31:0] instr_out,
  output logic [63:0] pcaddr_out,
  output logic        valid_out,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  localparam logic [63:0] c_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] c_PC_STEP    = 64'd4;

  logic [63:0] pc_q,      pc_d;
  logic [31:0] instr_q,   instr_d;
  logic [63:0] pcaddr_q,  pcaddr_d;
  logic        valid_q,   valid_d;
  logic [31:0] fcnt_q,    fcnt_d;
  logic [31:0] bcnt_q,    bcnt_d;

  // Next-state selection. Redirect beats stall: whatever is stalled in
  // IF/ID sits on the wrong path once a branch resolves taken.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcaddr_d = pcaddr_q;
    valid_d  = valid_q;
    fcnt_d   = fcnt_q;
    bcnt_d   = bcnt_q;
    if (br_taken) begin
      // Low address bits are dropped rather than faulting.
      pc_d     = br_target & c_ALIGN_MASK;
      instr_d  = NOP_INSTR;
      pcaddr_d = 64'd0;
      valid_d  = 1'b0;
      bcnt_d   = bcnt_q + 32'd1;
    end else if (stall) begin
      bcnt_d   = bcnt_q + 32'd1;
    end else begin
      pc_d     = pc_q + c_PC_STEP;   // 64-bit modulo, wrap is silent
      instr_d  = imem_instr;
      pcaddr_d = pc_q;
      valid_d  = 1'b1;
      fcnt_d   = fcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC & c_ALIGN_MASK;
      instr_q  <= NOP_INSTR;
      pcaddr_q <= 64'd0;
      valid_q  <= 1'b0;
      fcnt_q   <= 32'd0;
      bcnt_q   <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcaddr_q <= pcaddr_d;
      valid_q  <= valid_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // Memory address is the PC itself; no pipeline register in between.
  assign imem_addr  = pc_q;
  assign pc_out     = pc_q;
  assign instr_out  = instr_q;
  assign pcaddr_out = pcaddr_q;
  assign valid_out  = valid_q;
  assign fetch_cnt  = fcnt_q;
  assign bubble_cnt = bcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage: behavioural model of the
//             IF stage, per-cycle comparison, directed and random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = 64'd0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] pc_out;
  logic [31:0] instr_out;
  logic [63:0] pcaddr_out;
  logic        valid_out;
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .pcaddr_out (pcaddr_out),
    .valid_out  (valid_out),
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    if (a == 64'd0) return 32'h8B020020;
    if (a == 64'd4) return 32'hCB030041;
    h = a[33:2] * 32'h9E3779B1;
    return h ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  // ---------------- behavioural model ----------------
  logic [63:0] m_pc     = 64'd0;
  logic [31:0] m_instr  = c_NOP;
  logic [63:0] m_pcaddr = 64'd0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_fcnt   = 32'd0;
  logic [31:0] m_bcnt   = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 64'd0; m_instr = c_NOP; m_pcaddr = 64'd0;
      m_valid = 1'b0; m_fcnt = 32'd0; m_bcnt = 32'd0;
    end else if (br_taken) begin
      m_pc = {br_target[63:2], 2'b00};
      m_instr = c_NOP; m_pcaddr = 64'd0; m_valid = 1'b0;
      m_bcnt = m_bcnt + 1;
    end else if (stall) begin
      m_bcnt = m_bcnt + 1;
    end else begin
      m_instr = mem_word(m_pc);
      m_pcaddr = m_pc;
      m_valid = 1'b1;
      m_pc = m_pc + 64'd4;
      m_fcnt = m_fcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("pc_out",     pc_out,     m_pc);
    chk("imem_addr",  imem_addr,  m_pc);
    chk("instr_out",  {32'd0, instr_out}, {32'd0, m_instr});
    chk("pcaddr_out", pcaddr_out, m_pcaddr);
    chk("valid_out",  {63'd0, valid_out}, {63'd0, m_valid});
    chk("fetch_cnt",  {32'd0, fetch_cnt},  {32'd0, m_fcnt});
    chk("bubble_cnt", {32'd0, bubble_cnt}, {32'd0, m_bcnt});
    chk("cnt_sum",    {32'd0, fetch_cnt + bubble_cnt}, {32'd0, m_fcnt + m_bcnt});
  end

  // Advance one clock edge; land 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk); #1;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_pc",    pc_out, 64'd0);
    chk("rst_instr", {32'd0, instr_out}, {32'd0, c_NOP});
    chk("rst_valid", {63'd0, valid_out}, 64'd0);
    rst = 1'b0;

    // Reset then free run
    step();
    chk("e1_instr",  {32'd0, instr_out}, 64'h8B020020);
    chk("e1_pcaddr", pcaddr_out, 64'd0);
    chk("e1_pc",     pc_out, 64'd4);
    chk("e1_valid",  {63'd0, valid_out}, 64'd1);
    step();
    chk("e2_instr",  {32'd0, instr_out}, 64'hCB030041);
    chk("e2_pcaddr", pcaddr_out, 64'd4);
    chk("e2_pc",     pc_out, 64'd8);
    chk("e2_fcnt",   {32'd0, fetch_cnt}, 64'd2);
    chk("e2_bcnt",   {32'd0, bubble_cnt}, 64'd0);

    // Stall for 3 edges
    stall = 1'b1;
    repeat (3) step();
    chk("st_pc",     pc_out, 64'd8);
    chk("st_instr",  {32'd0, instr_out}, 64'hCB030041);
    chk("st_pcaddr", pcaddr_out, 64'd4);
    chk("st_bcnt",   {32'd0, bubble_cnt}, 64'd3);
    stall = 1'b0;
    step();
    chk("st_rel_pcaddr", pcaddr_out, 64'd8);
    chk("st_rel_pc",     pc_out, 64'd12);

    // Redirect
    br_taken = 1'b1; br_target = 64'h40;
    step();
    chk("br_pc",    pc_out, 64'h40);
    chk("br_valid", {63'd0, valid_out}, 64'd0);
    chk("br_instr", {32'd0, instr_out}, {32'd0, c_NOP});
    br_taken = 1'b0; br_target = 64'hDEAD_BEEF;
    step();
    chk("br2_pcaddr", pcaddr_out, 64'h40);
    chk("br2_valid",  {63'd0, valid_out}, 64'd1);

    // Redirect during stall, misaligned target
    stall = 1'b1; br_taken = 1'b1; br_target = 64'h103;
    step();
    chk("brst_pc",    pc_out, 64'h100);
    chk("brst_valid", {63'd0, valid_out}, 64'd0);
    chk("brst_bcnt",  {32'd0, bubble_cnt}, 64'd5);
    chk("brst_fcnt",  {32'd0, fetch_cnt}, 64'd4);
    stall = 1'b0;

    // PC wrap
    br_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    chk("wrap_pre", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    br_taken = 1'b0;
    step();
    chk("wrap_pc",     pc_out, 64'd0);
    chk("wrap_pcaddr", pcaddr_out, 64'hFFFF_FFFF_FFFF_FFFC);

    // Async reset mid-run at pc 0x20
    repeat (8) step();
    chk("pre_rst_pc", pc_out, 64'h20);
    rst = 1'b1; #1;
    chk("arst_pc",    pc_out, 64'd0);
    chk("arst_valid", {63'd0, valid_out}, 64'd0);
    chk("arst_fcnt",  {32'd0, fetch_cnt}, 64'd0);
    chk("arst_bcnt",  {32'd0, bubble_cnt}, 64'd0);
    #1 rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step();
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1; #1; rst = 1'b0;
      end
    end
    stall = 1'b0; br_taken = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
